// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2,
    EXEC = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [31:0] INST_NONE     = 32'h0;
  // Core-wide boot address; the fetch unit's RESET_PC defaults to it.
  localparam logic [31:0] CORE_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-side signal bundle: AXI4-Lite-style AR/R read channel plus the decode handshake.
interface ifu_fetch_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  modport master (
    output araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
    input  arready, rdata, rresp, rvalid, inst_ready
  );

  modport slave (
    input  araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
    output arready, rdata, rresp, rvalid, inst_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one read per instruction and hands
// the word to decode, then waits for the next-PC update before fetching again.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  ifu_fetch_if.master     bus
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            err_q, err_d;
  logic            resp_err;

  assign resp_err = (bus.rresp != RESP_OKAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= INST_NONE;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    case (state_q)
      REQ: begin
        if (bus.arready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.rvalid) begin
          inst_d    = resp_err ? INST_NONE : bus.rdata;
          inst_pc_d = pc_q;
          err_d     = resp_err;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (bus.inst_ready) state_d = EXEC;
      end
      EXEC: begin
        if (upd_valid) begin
          pc_d = upd_pc;
          if (upd_pc[1:0] == 2'b00) begin
            state_d = REQ;
          end else begin
            // Misaligned target: report it to decode without touching the bus.
            inst_d    = INST_NONE;
            inst_pc_d = upd_pc;
            err_d     = 1'b1;
            state_d   = OUT;
          end
        end
      end
      default: state_d = REQ;
    endcase
  end

  // arvalid is gated by rst_n so it stays low while reset is held, even though state is REQ.
  assign bus.arvalid    = rst_n && (state_q == REQ);
  assign bus.araddr     = (state_q == REQ) ? pc_q : '0;
  assign bus.rready     = (state_q == WAIT);
  assign bus.inst_valid = (state_q == OUT);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fetch_err  = err_q;

endmodule
